// File: rtl/dmux_ch_fifo.sv
// dmux_ch_fifo: routes one valid/ready stream into CH_N per-channel FIFOs,
// either unicast by data_in_sel or broadcast to every channel.
module dmux_ch_fifo #(
  parameter int DATA_W = 8,
  parameter int CH_N   = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_in_valid,
  input  logic [SEL_W-1:0]       data_in_sel,
  input  logic                   data_in_bcast,
  output logic                   data_in_ready,
  output logic [CH_N*DATA_W-1:0] data_out,
  output logic [CH_N-1:0]        data_out_valid,
  input  logic [CH_N-1:0]        data_out_ready,
  output logic [CH_N-1:0]        ch_full,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   CH_LIM   = 32'(CH_N);

  logic [DATA_W-1:0] mem_q [CH_N][DEPTH];
  logic [PW-1:0]     wr_q  [CH_N];
  logic [PW-1:0]     wr_d  [CH_N];
  logic [PW-1:0]     rd_q  [CH_N];
  logic [PW-1:0]     rd_d  [CH_N];
  logic [CW-1:0]     cnt_q [CH_N];
  logic [CW-1:0]     cnt_d [CH_N];
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;

  logic [CH_N-1:0] hit;
  logic [CH_N-1:0] full;
  logic [CH_N-1:0] push;
  logic [CH_N-1:0] pop;
  logic            sel_ok;
  logic            accept;

  // Ready looks only at registered occupancy, never at data_out_ready.
  always_comb begin
    hit    = '0;
    full   = '0;
    pop    = '0;
    sel_ok = 32'(data_in_sel) < CH_LIM;
    for (int k = 0; k < CH_N; k++) begin
      hit[k]  = 32'(data_in_sel) == 32'(k);
      full[k] = cnt_q[k] == FULL_CNT;
      pop[k]  = (cnt_q[k] != '0) && data_out_ready[k];
    end
    data_in_ready = data_in_bcast ? ~|full : ~|(hit & full);
    accept        = data_in_valid && data_in_ready;
    push          = '0;
    if (accept) begin
      push = data_in_bcast ? '1 : hit;
    end
  end

  always_comb begin
    for (int k = 0; k < CH_N; k++) begin
      wr_d[k]  = push[k] ? wr_q[k] + 1'b1 : wr_q[k];
      rd_d[k]  = pop[k]  ? rd_q[k] + 1'b1 : rd_q[k];
      cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
    err_d = err_q;
    if (accept && !data_in_bcast && !sel_ok && err_q != '1) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_N; k++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[k][d] <= '0;
        end
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      err_q <= '0;
    end else begin
      for (int k = 0; k < CH_N; k++) begin
        if (push[k]) begin
          mem_q[k][wr_q[k]] <= data_in;
        end
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    data_out       = '0;
    data_out_valid = '0;
    for (int k = 0; k < CH_N; k++) begin
      data_out[k*DATA_W +: DATA_W] = mem_q[k][rd_q[k]];
      data_out_valid[k]            = cnt_q[k] != '0;
    end
  end

  assign ch_full = full;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_dmux_ch_fifo.sv
// tb_dmux_ch_fifo: queue-model scoreboard for dmux_ch_fifo (4 channels)
// plus a 3-channel instance for invalid-select handling.
module tb_dmux_ch_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  din  = '0;
  logic        div  = 1'b0;
  logic [1:0]  dsel = '0;
  logic        dbc  = 1'b0;
  logic [3:0]  dor  = '0;
  logic        drdy;
  logic [31:0] dout;
  logic [3:0]  dov;
  logic [3:0]  dfull;
  logic [7:0]  derr;

  logic [7:0]  d3_din = '0;
  logic        d3_v   = 1'b0;
  logic [1:0]  d3_sel = '0;
  logic        d3_bc  = 1'b0;
  logic [2:0]  d3_or  = '0;
  logic        d3_rdy;
  logic [23:0] d3_out;
  logic [2:0]  d3_ov;
  logic [2:0]  d3_full;
  logic [7:0]  d3_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmux_ch_fifo #(
    .DATA_W(8), .CH_N(4), .SEL_W(2), .DEPTH(DEPTH), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(div),
    .data_in_sel(dsel), .data_in_bcast(dbc),
    .data_in_ready(drdy),
    .data_out(dout), .data_out_valid(dov),
    .data_out_ready(dor), .ch_full(dfull),
    .err_cnt(derr)
  );

  dmux_ch_fifo #(
    .DATA_W(8), .CH_N(3), .SEL_W(2), .DEPTH(DEPTH), .ERR_W(8)
  ) dut3 (
    .clk(clk), .rst(rst),
    .data_in(d3_din), .data_in_valid(d3_v),
    .data_in_sel(d3_sel), .data_in_bcast(d3_bc),
    .data_in_ready(d3_rdy),
    .data_out(d3_out), .data_out_valid(d3_ov),
    .data_out_ready(d3_or), .ch_full(d3_full),
    .err_cnt(d3_err)
  );

  // Reference model: one queue per channel plus the error count.
  logic [7:0] q [4][$];
  int         merr = 0;
  logic [3:0] m_pop;
  logic       m_acc;
  logic [3:0] m_ev;
  logic [3:0] m_ef;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready(input logic bc, input logic [1:0] s);
    if (bc) begin
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() == DEPTH) return 1'b0;
      end
      return 1'b1;
    end
    return q[s].size() != DEPTH;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      merr = 0;
    end else begin
      m_acc = div && m_ready(dbc, dsel);
      for (int k = 0; k < 4; k++) begin
        m_pop[k] = (q[k].size() != 0) && dor[k];
      end
      for (int k = 0; k < 4; k++) begin
        if (m_pop[k]) void'(q[k].pop_front());
      end
      if (m_acc) begin
        if (dbc) begin
          for (int k = 0; k < 4; k++) q[k].push_back(din);
        end else begin
          q[dsel].push_back(din);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        m_ev[k] = q[k].size() != 0;
        m_ef[k] = q[k].size() == DEPTH;
      end
      chk("mon_valid", dov, m_ev);
      chk("mon_full", dfull, m_ef);
      chk("mon_err", derr, merr);
      chk("mon_ready", drdy, m_ready(dbc, dsel));
      for (int k = 0; k < 4; k++) begin
        if (m_ev[k]) chk("mon_data", dout[k*8 +: 8], q[k][0]);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic [1:0] s, input logic b,
                       input logic [3:0] o);
    div = v; din = d; dsel = s; dbc = b; dor = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", dov, 4'b0000);
    chk("rst_full", dfull, 4'b0000);
    chk("rst_err", derr, 8'd0);
    chk("rst_dout", dout, 32'd0);
    rst = 1'b0;

    drive(1, 8'h11, 2'd2, 0, 4'b0000);
    #1 chk("uni_ready", drdy, 1'b1);
    step();
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    chk("uni_valid", dov, 4'b0100);
    chk("uni_slice2", dout[23:16], 8'h11);
    chk("uni_err", derr, 8'd0);
    drive(0, 8'h00, 2'd0, 0, 4'b0100);
    step();

    drive(1, 8'hA5, 2'd0, 1, 4'b0000);
    step();
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    chk("bc_valid", dov, 4'b1111);
    for (int k = 0; k < 4; k++) chk("bc_slice", dout[k*8 +: 8], 8'hA5);
    drive(0, 8'h00, 2'd0, 0, 4'b0010);
    step();
    chk("bc_pop1", dov, 4'b1101);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    step();

    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 2'd0, 0, 4'b0000);
      step();
    end
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    chk("fill_full0", dfull[0], 1'b1);
    #1 chk("fill_rdy_sel0", drdy, 1'b0);
    dsel = 2'd3;
    #1 chk("fill_rdy_sel3", drdy, 1'b1);
    dbc = 1'b1;
    #1 chk("fill_rdy_bcast", drdy, 1'b0);
    drive(0, 8'h00, 2'd0, 0, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", dout[7:0], 8'(i));
      step();
    end
    chk("drain_empty", dov[0], 1'b0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h21 + 8'(i), 2'd0, 0, 4'b0000);
      step();
    end
    drive(1, 8'h25, 2'd0, 0, 4'b0001);
    #1 chk("pp_refused", drdy, 1'b0);
    step();
    chk("pp_after_pop", drdy, 1'b1);
    drive(1, 8'h25, 2'd0, 0, 4'b0000);
    step();
    chk("pp_full_again", dfull[0], 1'b1);
    drive(0, 8'h00, 2'd0, 0, 4'b0001);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h30 + 8'(i), 2'd0, 0, 4'b0001);
      step();
      chk("pp_full_stays0", dfull[0], 1'b0);
    end
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    repeat (4) step();

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom),
            2'($urandom), $urandom_range(0, 7) == 0,
            4'($urandom));
      step();
    end

    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h40 + 8'(i), 2'd2, 0, 4'b0000);
      step();
    end
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", dov, 4'b0000);
    chk("arst_dout", dout, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 8'h5A, 2'd2, 0, 4'b0000);
    chk("post_rst_empty", dov, 4'b0000);
    step();
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    chk("post_rst_valid", dov, 4'b0100);
    chk("post_rst_data", dout[23:16], 8'h5A);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    step();

    d3_v = 1'b1; d3_sel = 2'd0; d3_din = 8'h77;
    step();
    d3_v = 1'b0;
    chk("c3_valid", d3_ov, 3'b001);
    chk("c3_data", d3_out[7:0], 8'h77);
    d3_or = 3'b111;
    step();
    chk("c3_drained", d3_ov, 3'b000);
    d3_or = 3'b000;
    d3_v = 1'b1; d3_sel = 2'd3;
    for (int i = 1; i <= 300; i++) begin
      d3_din = 8'($urandom);
      #1 chk("c3_bad_ready", d3_rdy, 1'b1);
      step();
      chk("c3_bad_valid", d3_ov, 3'b000);
      if (i == 1) chk("c3_err_first", d3_err, 8'd1);
      if (i == 200) chk("c3_err_200", d3_err, 8'd200);
    end
    d3_v = 1'b0;
    chk("c3_err_sat", d3_err, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
